// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with a one-byte holding register, valid/read
//           handshake and sticky overrun / framing error flags.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8,
    parameter int MIN_PERIOD  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [15:0]          clock_divider,
    input  logic                 rx,
    input  logic                 read_en,
    input  logic                 clear_errors,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 overrun,
    output logic                 framing_error,
    output logic                 busy
);

    localparam logic [15:0]        c_MIN_PERIOD = 16'(MIN_PERIOD);
    localparam int                 c_IDX_W      = $clog2(DATA_BITS + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    state_t                 r_state;
    logic [15:0]            r_period;
    logic [15:0]            r_cnt;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_ferr;
    logic                   r_busy;

    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_sample;
    logic [15:0]            w_period;

    assign w_rx_s   = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_rx_prev & ~w_rx_s;
    assign w_sample = (r_cnt == 16'd0);
    assign w_period = (clock_divider < c_MIN_PERIOD) ? c_MIN_PERIOD : clock_divider;

    // Idle-high reset value keeps a spurious start edge from appearing after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_period  <= 16'd0;
            r_cnt     <= 16'd0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Clears come first so a same-cycle set or delivery below wins.
            if (clear_errors) begin
                r_overrun <= 1'b0;
                r_ferr    <= 1'b0;
            end
            if (read_en && r_valid) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_period <= w_period;
                        r_cnt    <= (w_period >> 1) - 16'd1;
                        r_state  <= S_START;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!w_rx_s) begin
                        r_cnt     <= r_period - 16'd1;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_cnt   <= r_period - 16'd1;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_LAST_IDX) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (w_rx_s) begin
                        if (!r_valid || read_en) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = r_data;
    assign data_valid    = r_valid;
    assign overrun       = r_overrun;
    assign framing_error = r_ferr;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx driven by a frame-level line model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_SYNC = 2;
    localparam int c_MIN  = 4;

    logic        clock         = 1'b0;
    logic        reset_n       = 1'b0;
    logic [15:0] clock_divider = 16'd12;
    logic        rx            = 1'b1;
    logic        read_en       = 1'b0;
    logic        clear_errors  = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        overrun;
    logic        framing_error;
    logic        busy;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          cap_cyc   = 0;
    bit          auto_read = 1'b0;
    logic [7:0]  got[$];
    logic        prev_dv   = 1'b0;
    logic [7:0]  prev_do   = 8'h00;

    uart_rx #(
        .SYNC_STAGES(c_SYNC),
        .DATA_BITS  (8),
        .MIN_PERIOD (c_MIN)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_divider(clock_divider),
        .rx           (rx),
        .read_en      (read_en),
        .clear_errors (clear_errors),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .overrun      (overrun),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Every byte that appears in the holding register is logged once.
    always @(negedge clock) begin
        if (data_valid && (!prev_dv || data_out != prev_do)) begin
            got.push_back(data_out);
            cap_cyc = cyc;
        end
        prev_dv = data_valid;
        prev_do = data_out;
    end

    function automatic int eff_period(input int div);
        return (div < c_MIN) ? c_MIN : div;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (auto_read) begin
            if (data_valid && !read_en) read_en = 1'b1;
            else                        read_en = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int div, input bit scramble);
        int p;
        int k;
        p = eff_period(div);
        for (int i = 0; i < 10 * p; i++) begin
            k = i / p;
            if (i == 0) clock_divider = 16'(div);
            else if (scramble && i == 4) clock_divider = 16'($urandom_range(0, 65535));
            if (k == 0)      rx = 1'b0;
            else if (k == 9) rx = stop;
            else             rx = b[k-1];
            tick();
        end
        clock_divider = 16'(div);
    endtask

    task automatic read_pulse();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({data_out, data_valid, overrun, framing_error, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold: got %h required 000", {data_out, data_valid, overrun, framing_error, busy});
        end
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if ({data_out, data_valid, overrun, framing_error, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_release: got %h required 000", {data_out, data_valid, overrun, framing_error, busy});
        end
    endtask

    task automatic test_basic();
        int start;
        int lat_exp;
        got.delete();
        auto_read = 1'b0;
        start   = cyc;
        lat_exp = c_SYNC + 12 / 2 + 9 * 12 + 1;
        send_frame(8'h55, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (3) tick();
        checks++;
        if (got.size() != 1 || got[0] !== 8'h55) begin
            failures++;
            $display("FAIL basic_data: got %0d bytes first %h required 1 byte 55", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if ((cap_cyc - start) < lat_exp - 1 || (cap_cyc - start) > lat_exp + 1) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d +-1", cap_cyc - start, lat_exp);
        end
        checks++;
        if ({data_valid, overrun, framing_error} !== 3'b100) begin
            failures++;
            $display("FAIL basic_flags: got %b required 100", {data_valid, overrun, framing_error});
        end
        read_pulse();
    endtask

    task automatic test_overrun();
        auto_read = 1'b0;
        send_frame(8'hA3, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (2) tick();
        send_frame(8'h0F, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (3) tick();
        checks++;
        if (data_out !== 8'hA3 || data_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got data=%h valid=%b ovr=%b required data=a3 valid=1 ovr=1", data_out, data_valid, overrun);
        end
        read_pulse();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_read: got valid=%b required 0", data_valid);
        end
        clear_pulse();
        checks++;
        if (overrun !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got ovr=%b ferr=%b required 0 0", overrun, framing_error);
        end
    endtask

    task automatic test_glitch();
        int n;
        got.delete();
        auto_read     = 1'b0;
        clock_divider = 16'd12;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_rise: got %b required 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || n > 12) begin
            failures++;
            $display("FAIL glitch_busy_fall: got busy=%b after %0d cycles required 0 within 12", busy, n);
        end
        repeat (5) tick();
        checks++;
        if ({data_valid, overrun, framing_error} !== 3'b000 || got.size() != 0) begin
            failures++;
            $display("FAIL glitch_quiet: got flags=%b bytes=%0d required 000 and 0", {data_valid, overrun, framing_error}, got.size());
        end
    endtask

    task automatic test_framing();
        got.delete();
        auto_read = 1'b1;
        send_frame(8'h81, 1'b0, 12, 1'b0);
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        repeat (30) tick();
        send_frame(8'h3C, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (5) tick();
        checks++;
        if (framing_error !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL framing_flag: got ferr=%b ovr=%b required 1 0", framing_error, overrun);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 8'h3C) begin
            failures++;
            $display("FAIL framing_data: got %0d bytes first %h required 1 byte 3c", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        clear_pulse();
        checks++;
        if (framing_error !== 1'b0) begin
            failures++;
            $display("FAIL framing_clear: got %b required 0", framing_error);
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        auto_read = 1'b0;
        send_frame(8'hFF, 1'b1, 2, 1'b0);
        send_frame(8'h00, 1'b1, 2, 1'b0);
        // Stop sample of the second frame falls in this cycle.
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        rx = 1'b1;
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h00 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_coincide: got valid=%b data=%h ovr=%b required 1 00 0", data_valid, data_out, overrun);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'hFF || got[got.size()-1] !== 8'h00) begin
            failures++;
            $display("FAIL b2b_bytes: got %0d bytes required ff then 00", got.size());
        end
        read_pulse();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        auto_read = 1'b0;
        send_frame(8'h11, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (3) tick();
        b = 8'h22;
        clock_divider = 16'd12;
        for (int i = 0; i < 5 * 12; i++) begin
            rx = (i < 12) ? 1'b0 : b[i / 12 - 1];
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, overrun, framing_error, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_async: got %h required 000", {data_out, data_valid, overrun, framing_error, busy});
        end
        rx = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        got.delete();
        auto_read = 1'b1;
        send_frame(8'h7E, 1'b1, 12, 1'b0);
        rx = 1'b1;
        repeat (5) tick();
        checks++;
        if (got.size() != 1 || got[0] !== 8'h7E || overrun !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_next: got %0d bytes first %h ovr=%b ferr=%b required 1 byte 7e no flags",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx, overrun, framing_error);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         div;
        got.delete();
        auto_read = 1'b1;
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            div = (n == 0) ? 600 : int'($urandom_range(0, 40));
            rx  = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
            exp_q.push_back(b);
            send_frame(b, 1'b1, div, 1'b1);
        end
        rx = 1'b1;
        repeat (10) tick();
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d bytes required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (overrun !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL random_flags: got ovr=%b ferr=%b required 0 0", overrun, framing_error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; completes the receive half of the UART device that currently only transmits.
- Recovers 8N1 frames from the asynchronous rx pin using the same baud `clock_divider` value the transmitter uses.
- Holds one received byte in an output register with a valid/read handshake.
- Reports sticky overrun and framing errors for the device status register.

Parameters:
- SYNC_STAGES, 2, flops in the rx input synchronizer (minimum 2).
- DATA_BITS, 8, data bits per frame, sent LSB first.
- MIN_PERIOD, 4, minimum bit period in clocks; `clock_divider` values below this are clamped up to it.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clock_divider  input  16  bit period P in clocks, where P = max(clock_divider, MIN_PERIOD).
- rx  input  1  serial line; idles high; asynchronous to clock.
- read_en  input  1  consumer acknowledges data_out this cycle.
- clear_errors  input  1  one-cycle pulse; clears overrun and framing_error.
- data_out  output  DATA_BITS  last received byte.
- data_valid  output  1  data_out holds an unread byte.
- overrun  output  1  sticky; a byte was dropped because the holding register was full.
- framing_error  output  1  sticky; a stop bit was sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - synchronizer flops and the previous-rx flop are forced to 1;
  - state=IDLE, data_out=0, data_valid=0, overrun=0, framing_error=0, busy=0;
  - counters and shift register are 0.
- Reset asserted mid-frame aborts the frame; no partial byte is ever delivered.
- Input: rx passes through SYNC_STAGES flops; rx_s is the synchronized value.
- Edge detect: a falling edge is rx_s=0 while previous rx_s=1.
- Timing:
  - P is latched at falling-edge detection; changes to clock_divider mid-frame are ignored.
  - The start-bit sample occurs floor(P/2) cycles after the detect cycle.
  - Each later sample occurs exactly P cycles after the previous one.
- State machine:
  - IDLE: on falling edge, latch P, load counter, go to START. Otherwise stay.
  - START: at the sample point, if rx_s=0 go to DATA with bit index 0. If rx_s=1 (glitch), go to IDLE with no flag.
  - DATA: at each sample point, shift rx_s into the shift register MSB side so that bit 0 arrives first. After DATA_BITS samples, go to STOP.
  - STOP: at the sample point:
    - rx_s=1: deliver the byte, go to IDLE.
    - rx_s=0: set framing_error, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. No falling edge is armed until rx_s has been seen high (handles line break).
- Delivery (the cycle after the stop sample):
  - data_valid=0: data_out<=byte, data_valid<=1.
  - data_valid=1 and read_en=1 in the same cycle: data_out<=new byte, data_valid stays 1, no overrun.
  - data_valid=1 and read_en=0: new byte dropped, data_out unchanged, overrun<=1.
- Read: read_en with data_valid=1 clears data_valid on the next edge. read_en with data_valid=0 has no effect.
- Errors:
  - clear_errors clears both flags next cycle.
  - If clear_errors coincides with a new error event, the flag ends up set (set wins).
- Back-to-back frames: a falling edge detected in the cycle immediately after the STOP sample must be accepted. No dead cycles are allowed beyond the IDLE transition.
- Latency: data_valid rises SYNC_STAGES + floor(P/2) + (DATA_BITS+1)*P + 1 cycles after the rx pin falls, ±1 for synchronizer phase.
- Counters are 16 bits. P=65535 must work without wrap errors.

Test Plan:
- clock_divider=12; send frame 0x55 on rx → data_valid rises about 2+6+108+1=117 cycles after the start edge (±1); data_out=0x55; framing_error=0, overrun=0.
- Send 0xA3, no read_en, then send 0x0F → data_out stays 0xA3, overrun=1; then read_en pulse → data_valid=0; clear_errors pulse → overrun=0.
- Hold rx low for 3 cycles only (P=12) → returns to IDLE; data_valid=0; no flags; busy returns to 0 after about 8 cycles.
- Send 0x81 with the stop bit driven low, then rx held low 40 cycles, then high, then frame 0x3C → framing_error=1; 0x81 never delivered; 0x3C received correctly.
- Two back-to-back frames 0xFF, 0x00 at clock_divider=2 (clamped to P=4), with read_en asserted in the delivery cycle of the second → both bytes observed, no overrun.
- Assert reset_n=0 for 1 cycle mid DATA state → all outputs return to 0 asynchronously; the next full frame 0x7E is received correctly.
